key_debounce8: RTL and testbench

Upstream input stage for the 8-to-3 encoder (`encoder83`). It takes eight raw push-button lines, synchronizes and debounces each one, and turns each new press into a single one-hot 8-bit event. The event is presented on `oData` with a valid/ack handshake; `oData` drives the encoder's `iData` directly. Only one event is issued per press, however long the key is held.

---
 rtl/key_debounce8.sv | 117 +++++++++++
 tb/tb_key_debounce8.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce8.sv
// Eight-key synchronizer/debouncer that issues one one-hot event per press over a valid/ack handshake.
// Define KEY_SYNC_EN to insert the 2-flop input synchronizer; leave it undefined for inputs already on iClk.
module key_debounce8 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iKey,
  input  logic       iAck,
  output logic [7:0] oData,
  output logic       oValid
);

  // state    | meaning
  // ST_IDLE  | no event pending, waiting for any debounced key
  // ST_HOLD  | event presented on oData/oValid, waiting for iAck
  // ST_WAIT  | event taken, waiting for every debounced key to release
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       w_sync;
  logic [7:0]       r_deb;
  logic [CNT_W-1:0] r_cnt [8];
  logic [7:0]       w_hi;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_valid_nxt;

`ifdef KEY_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= iKey;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync = r_sync2;
`else
  assign w_sync = iKey;
`endif

  // A key's counter only advances while its input disagrees with the accepted level.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_deb <= '0;
      for (int k = 0; k < 8; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (w_sync[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == LP_TC) begin
          r_deb[k] <= w_sync[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Ascending scan so the highest-index held key wins.
  always_comb begin
    w_hi = '0;
    for (int k = 0; k < 8; k++) begin
      if (r_deb[k]) begin
        w_hi    = '0;
        w_hi[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      oData   <= '0;
      oValid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      oData   <= w_data_nxt;
      oValid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|r_deb)        w_state_nxt = ST_HOLD;
      ST_HOLD: if (iAck)          w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_deb == 8'd0) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_data_nxt  = '0;
    w_valid_nxt = (w_state_nxt == ST_HOLD);
    case (r_state)
      ST_IDLE: w_data_nxt = w_hi;
      ST_HOLD: w_data_nxt = iAck ? 8'd0 : oData;
      default: w_data_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_key_debounce8.sv
// Self-checking bench for key_debounce8: directed scenarios plus randomized traffic against a window-based model.
module tb_key_debounce8;
  localparam int DEB = 4;
`ifdef KEY_SYNC_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = DEB + 1;
`endif

  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iKey;
  logic       iAck;
  logic [7:0] oData;
  logic       oValid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 iClk = ~iClk;

  key_debounce8 #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iKey  (iKey),
    .iAck  (iAck),
    .oData (oData),
    .oValid(oValid)
  );

  // Reference: a key flips once the last DEB sampled levels all disagree with it;
  // events are tracked as pending / waiting-for-release flags.
  logic [7:0] m_k1, m_k2, m_sync, m_deb, m_flip, m_hi, m_data;
  logic [7:0] m_hist [DEB];
  logic       m_pend, m_wait;

  always_comb begin
`ifdef KEY_SYNC_EN
    m_sync = m_k2;
`else
    m_sync = iKey;
`endif
    m_flip = '0;
    for (int k = 0; k < 8; k++) begin
      m_flip[k] = (m_sync[k] != m_deb[k]);
      for (int j = 0; j < DEB - 1; j++)
        if (m_hist[j][k] == m_deb[k]) m_flip[k] = 1'b0;
    end
    m_hi = '0;
    for (int k = 0; k < 8; k++)
      if (m_deb[k]) begin
        m_hi    = '0;
        m_hi[k] = 1'b1;
      end
  end

  always @(posedge iClk) begin
    if (iRst) begin
      m_k1 <= '0; m_k2 <= '0; m_deb <= '0; m_data <= '0;
      m_pend <= 1'b0; m_wait <= 1'b0;
      for (int j = 0; j < DEB; j++) m_hist[j] <= '0;
    end else begin
      m_k1 <= iKey;
      m_k2 <= m_k1;
      m_hist[0] <= m_sync;
      for (int j = 1; j < DEB; j++) m_hist[j] <= m_hist[j-1];
      m_deb <= m_deb ^ m_flip;
      if (m_pend) begin
        if (iAck) begin
          m_pend <= 1'b0; m_data <= '0; m_wait <= 1'b1;
        end
      end else if (m_wait) begin
        if (m_deb == 8'd0) m_wait <= 1'b0;
      end else if (m_deb != 8'd0) begin
        m_pend <= 1'b1; m_data <= m_hi;
      end
    end
  end

  task automatic tick;
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic test_reset;
    iRst = 1'b1; iKey = 8'($urandom); iAck = 1'b1;
    tick; tick;
    n_checks++;
    if (oValid !== 1'b0 || oData !== 8'd0)
      $display("FAIL reset_state got v=%b d=%b want v=0 d=00000000", oValid, oData);
    else n_pass++;
    iRst = 1'b0; iKey = 8'd0; iAck = 1'b0;
    repeat (3) begin
      tick;
      n_checks++;
      if (oValid !== m_pend || oData !== m_data)
        $display("FAIL reset_idle got v=%b d=%b want v=%b d=%b", oValid, oData, m_pend, m_data);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press;
    iKey = 8'b0010_0000;
    for (int e = 1; e <= LAT + 12; e++) begin
      tick;
      n_checks++;
      if (oValid !== m_pend || oData !== m_data)
        $display("FAIL clean_model edge %0d got v=%b d=%b want v=%b d=%b", e, oValid, oData, m_pend, m_data);
      else n_pass++;
      n_checks++;
      if (e < LAT && (oValid !== 1'b0 || oData !== 8'd0))
        $display("FAIL clean_early edge %0d got v=%b d=%b want v=0 d=00000000", e, oValid, oData);
      else if (e >= LAT && (oValid !== 1'b1 || oData !== 8'b0010_0000))
        $display("FAIL clean_event edge %0d got v=%b d=%b want v=1 d=00100000", e, oValid, oData);
      else n_pass++;
    end
    iAck = 1'b1; tick; iAck = 1'b0;
    n_checks++;
    if (oValid !== 1'b0 || oData !== 8'd0)
      $display("FAIL clean_ack got v=%b d=%b want v=0 d=00000000", oValid, oData);
    else n_pass++;
    iKey = 8'd0;
    repeat (DEB + 4) begin
      tick;
      n_checks++;
      if (oValid !== m_pend || oData !== m_data)
        $display("FAIL clean_release got v=%b d=%b want v=%b d=%b", oValid, oData, m_pend, m_data);
      else n_pass++;
    end
  endtask

  task automatic test_glitch;
    iKey = 8'b0000_1000;
    repeat (DEB - 1) tick;
    iKey = 8'd0;
    repeat (20) begin
      tick;
      n_checks++;
      if (oValid !== 1'b0 || oData !== 8'd0 || oValid !== m_pend)
        $display("FAIL glitch got v=%b d=%b want v=0 d=00000000", oValid, oData);
      else n_pass++;
    end
  endtask

  task automatic test_priority;
    int cyc;
    iKey = 8'b0100_0010;
    cyc = 0;
    while (oValid !== 1'b1 && cyc < LAT + 5) begin
      tick; cyc++;
      n_checks++;
      if (oValid !== m_pend || oData !== m_data)
        $display("FAIL prio_model got v=%b d=%b want v=%b d=%b", oValid, oData, m_pend, m_data);
      else n_pass++;
    end
    n_checks++;
    if (oValid !== 1'b1 || oData !== 8'b0100_0000)
      $display("FAIL prio_event got v=%b d=%b want v=1 d=01000000", oValid, oData);
    else n_pass++;
    iAck = 1'b1; tick; iAck = 1'b0;
    repeat (15) begin
      tick;
      n_checks++;
      if (oValid !== 1'b0 || oData !== 8'd0)
        $display("FAIL prio_no_low_event got v=%b d=%b want v=0 d=00000000", oValid, oData);
      else n_pass++;
    end
    iKey = 8'd0;
    repeat (DEB + 4) tick;
  endtask

  task automatic test_single_event;
    int cyc;
    iKey = 8'b1000_0000;
    cyc = 0;
    while (oValid !== 1'b1 && cyc < LAT + 5) begin
      tick; cyc++;
    end
    n_checks++;
    if (oValid !== 1'b1 || oData !== 8'b1000_0000 || cyc != LAT)
      $display("FAIL single_first got v=%b d=%b lat=%0d want v=1 d=10000000 lat=%0d", oValid, oData, cyc, LAT);
    else n_pass++;
    tick;
    iAck = 1'b1; tick; iAck = 1'b0;
    n_checks++;
    if (oValid !== 1'b0 || oData !== 8'd0)
      $display("FAIL single_ack got v=%b d=%b want v=0 d=00000000", oValid, oData);
    else n_pass++;
    repeat (30) begin
      tick;
      n_checks++;
      if (oValid !== 1'b0 || oValid !== m_pend)
        $display("FAIL single_no_repeat got v=%b want v=0", oValid);
      else n_pass++;
    end
    iKey = 8'd0;
    repeat (DEB + 4) tick;
    iKey = 8'b1000_0000;
    cyc = 0;
    while (oValid !== 1'b1 && cyc < LAT + 5) begin
      tick; cyc++;
    end
    n_checks++;
    if (oValid !== 1'b1 || oData !== 8'b1000_0000 || cyc != LAT)
      $display("FAIL single_repress got v=%b d=%b lat=%0d want v=1 d=10000000 lat=%0d", oValid, oData, cyc, LAT);
    else n_pass++;
    iAck = 1'b1; tick; iAck = 1'b0;
    iKey = 8'd0;
    repeat (DEB + 4) tick;
  endtask

  task automatic test_reset_hold;
    int cyc;
    iKey = 8'b0000_0100;
    cyc = 0;
    while (oValid !== 1'b1 && cyc < LAT + 5) begin
      tick; cyc++;
    end
    n_checks++;
    if (oValid !== 1'b1 || oData !== 8'b0000_0100)
      $display("FAIL rsthold_event got v=%b d=%b want v=1 d=00000100", oValid, oData);
    else n_pass++;
    iRst = 1'b1; tick; iRst = 1'b0;
    n_checks++;
    if (oValid !== 1'b0 || oData !== 8'd0)
      $display("FAIL rsthold_clear got v=%b d=%b want v=0 d=00000000", oValid, oData);
    else n_pass++;
    cyc = 0;
    while (oValid !== 1'b1 && cyc < LAT + 5) begin
      tick; cyc++;
    end
    n_checks++;
    if (oValid !== 1'b1 || oData !== 8'b0000_0100 || cyc != LAT)
      $display("FAIL rsthold_fresh got v=%b d=%b lat=%0d want v=1 d=00000100 lat=%0d", oValid, oData, cyc, LAT);
    else n_pass++;
    iAck = 1'b1; tick; iAck = 1'b0;
    iKey = 8'd0;
    repeat (DEB + 4) tick;
  endtask

  task automatic test_random;
    int hold;
    for (int it = 0; it < 300; it++) begin
      iKey = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        iAck = ($urandom_range(0, 9) < 3);
        iRst = ($urandom_range(0, 99) == 0);
        tick;
        n_checks++;
        if (oValid !== m_pend || oData !== m_data)
          $display("FAIL random it %0d got v=%b d=%b want v=%b d=%b", it, oValid, oData, m_pend, m_data);
        else n_pass++;
      end
    end
    iRst = 1'b0; iAck = 1'b0; iKey = 8'd0;
  endtask

  initial begin
    iRst = 1'b1; iKey = 8'd0; iAck = 1'b0;
    @(negedge iClk);
    test_reset;
    test_clean_press;
    test_glitch;
    test_priority;
    test_single_event;
    test_reset_hold;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
